// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter between instruction fetch and data paths.
// One access is latched at a time, data requests win, and a stalled RAM trips a sticky timeout.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  input  logic        halt,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        timeout
);

  // state | meaning
  // IDLE  | no access in flight, arbitrating requests
  // IACC  | instruction read in flight
  // DACC  | data read or write in flight
  // ERR   | RAM never answered; held until reset
  typedef enum logic [1:0] {IDLE, IACC, DACC, ERR} state_t;

  localparam logic [9:0] TC_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [9:0]  cnt;
  logic [31:0] iload_q;
  logic [31:0] dload_q;
  logic        i_done;
  logic        d_done;

  assign i_done = (state == IACC) && ramready;
  assign d_done = (state == DACC) && ramready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      cnt      <= '0;
      iload_q  <= '0;
      dload_q  <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (dREN || dWEN) begin
            state    <= DACC;
            ramaddr  <= daddr;
            ramstore <= dstore;
            ramWEN   <= dWEN;
            ramREN   <= !dWEN;
          end else if (iREN && !halt) begin
            state   <= IACC;
            ramaddr <= iaddr;
            ramREN  <= 1'b1;
            ramWEN  <= 1'b0;
          end
        end
        IACC, DACC: begin
          // a ready in the terminal-count cycle still completes the access
          if (ramready) begin
            state  <= IDLE;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            if (state == IACC)
              iload_q <= ramload;
            else if (ramREN)
              dload_q <= ramload;
          end else if (cnt == TC_LAST) begin
            state   <= ERR;
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        ERR: begin
          ramREN <= 1'b0;
          ramWEN <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign iwait = iREN && !i_done;
  assign dwait = (dREN || dWEN) && !d_done;
  assign iload = i_done ? ramload : iload_q;
  assign dload = (d_done && ramREN) ? ramload : dload_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, checked by a
// scoreboard of expected RAM accesses built from a reference memory.
module tb_mem_arbiter;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN, halt;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic        ramready, timeout;

  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload), .halt(halt),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .timeout(timeout)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    bit          instr;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          fixed_delay = -1;
  bit          stall = 0;
  bit          inject_ready = 0;
  logic [31:0] exp_iload = '0;
  logic [31:0] exp_dload = '0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // RAM responder: answers each access after a chosen number of wait cycles
  initial begin
    bit busy;
    int wcnt, tgt;
    busy = 0; wcnt = 0; tgt = 0;
    ramready = 1'b0;
    ramload  = '0;
    forever begin
      @(posedge CLK); #1;
      if (!nRST) begin
        busy = 0;
        ramready = 1'b0;
      end else if (ramREN || ramWEN) begin
        if (!busy) begin
          busy = 1;
          wcnt = 0;
          tgt  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        end
        if (!stall && wcnt == tgt) begin
          ramready = 1'b1;
          if (ramWEN) ram_mem[ramaddr] = ramstore;
          else ramload = ram_rd(ramaddr);
        end else begin
          ramready = 1'b0;
          wcnt++;
        end
      end else begin
        busy = 0;
        ramready = inject_ready;
        if (inject_ready) ramload = 32'hFFFF_FFFF;
      end
    end
  end

  // Monitor: compares every cycle, pops the scoreboard on each RAM completion
  initial begin
    bit   prev_compl, compl, have, ci, cd, cdr;
    exp_t f;
    prev_compl = 0;
    forever begin
      @(negedge CLK);
      compl = nRST && ramready && (ramREN || ramWEN);
      have  = sbq.size() > 0;
      f.instr = 0; f.wr = 0; f.addr = '0; f.data = '0;
      if (have) f = sbq[0];
      if (compl && !have) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_access at %0t: addr %h ren %0d wen %0d, expected none", $time, ramaddr, ramREN, ramWEN);
      end
      ci  = compl && have && f.instr;
      cd  = compl && have && !f.instr;
      cdr = cd && !f.wr;
      check("iwait", 32'(iwait), 32'(iREN && !ci));
      check("dwait", 32'(dwait), 32'((dREN || dWEN) && !cd));
      check("iload", iload, ci ? f.data : exp_iload);
      check("dload", dload, cdr ? f.data : exp_dload);
      check("en_exclusive", 32'(ramREN && ramWEN), 32'd0);
      if (prev_compl) check("idle_gap", 32'(ramREN || ramWEN), 32'd0);
      if (compl && have) begin
        check("ramaddr", ramaddr, f.addr);
        check("ramWEN", 32'(ramWEN), 32'(f.wr));
        check("ramREN", 32'(ramREN), 32'(!f.wr));
        if (f.wr) check("ramstore", ramstore, f.data);
        if (ci)  exp_iload = f.data;
        if (cdr) exp_dload = f.data;
        void'(sbq.pop_front());
      end
      prev_compl = compl;
    end
  end

  // dop: 0 none, 1 read, 2 write, 3 read+write (write wins)
  task automatic issue(input bit do_i, input int dop, input logic [31:0] ia,
                       input logic [31:0] da, input logic [31:0] ds);
    exp_t e;
    bit   idone, ddone;
    if (dop != 0) begin
      e.instr = 0; e.wr = (dop >= 2); e.addr = da;
      if (e.wr) begin
        e.data = ds;
        ref_mem[da] = ds;
      end else e.data = ref_rd(da);
      sbq.push_back(e);
    end
    if (do_i) begin
      e.instr = 1; e.wr = 0; e.addr = ia; e.data = ref_rd(ia);
      sbq.push_back(e);
    end
    @(posedge CLK); #2;
    iREN = do_i; iaddr = ia;
    dREN = (dop == 1 || dop == 3); dWEN = (dop >= 2);
    daddr = da; dstore = ds;
    idone = !do_i; ddone = (dop == 0);
    for (int c = 0; c < 100 && !(idone && ddone); c++) begin
      @(negedge CLK);
      if (iREN && !iwait) idone = 1;
      if ((dREN || dWEN) && !dwait) ddone = 1;
      @(posedge CLK); #2;
      if (idone) iREN = 1'b0;
      if (ddone) begin dREN = 1'b0; dWEN = 1'b0; end
      // the granted access is already latched; these must not disturb it
      daddr = $urandom; dstore = $urandom;
      if (dop == 0) iaddr = $urandom;
    end
    if (!(idone && ddone)) begin
      n_tests++; n_fail++;
      $display("FAIL handshake at %0t: idone %0d ddone %0d, expected both 1", $time, idone, ddone);
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    end
  endtask

  task automatic wait_wait_low(input bit sel_i, input string nm);
    bit seen;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge CLK);
      if (sel_i ? !iwait : !dwait) seen = 1;
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL %s at %0t: wait never dropped, expected completion", nm, $time);
    end
  endtask

  task automatic clear_model();
    sbq.delete();
    exp_iload = '0;
    exp_dload = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    nRST = 1'b1;
    iREN = 0; dREN = 0; dWEN = 0; halt = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    #1 nRST = 1'b0;
    @(negedge CLK);
    check("rst_ramREN", 32'(ramREN), 0);
    check("rst_ramWEN", 32'(ramWEN), 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ramstore", ramstore, 0);
    check("rst_timeout", 32'(timeout), 0);
    @(negedge CLK); #2 nRST = 1'b1;

    // instruction fetch, ready two cycles after the enable
    ram_mem[32'h40] = 32'h8C22_0004;
    ref_mem[32'h40] = 32'h8C22_0004;
    fixed_delay = 2;
    issue(1, 0, 32'h40, 0, 0);
    check("ifetch_iload_reg", iload, 32'h8C22_0004);

    // data beats instruction; terminal-count ready still completes
    fixed_delay = 3;
    issue(1, 2, 32'h44, 32'h100, 32'hDEAD_BEEF);
    check("prio_mem_written", ram_rd(32'h100), 32'hDEAD_BEEF);
    fixed_delay = -1;

    // halt blocks instruction grants but not data
    @(posedge CLK); #2;
    halt = 1; iREN = 1; iaddr = 32'h80;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      check("halt_no_en", 32'(ramREN || ramWEN), 0);
    end
    e.instr = 0; e.wr = 0; e.addr = 32'h200; e.data = ref_rd(32'h200);
    sbq.push_back(e);
    @(posedge CLK); #2;
    dREN = 1; daddr = 32'h200;
    wait_wait_low(0, "halt_dread");
    @(posedge CLK); #2 dREN = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("halt_no_en2", 32'(ramREN || ramWEN), 0);
    end
    check("halt_dload", dload, ref_rd(32'h200));
    e.instr = 1; e.wr = 0; e.addr = 32'h80; e.data = ref_rd(32'h80);
    sbq.push_back(e);
    @(posedge CLK); #2 halt = 0;
    wait_wait_low(1, "unhalt_ifetch");
    @(posedge CLK); #2 iREN = 0;

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      bit do_i;
      int dop;
      do_i = 1'($urandom_range(0, 1));
      dop  = int'($urandom_range(0, 3));
      if (!do_i && dop == 0) do_i = 1;
      issue(do_i, dop, 32'($urandom_range(0, 15)) << 2,
            32'($urandom_range(0, 15)) << 2, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
    end

    // withdrawn instruction request still completes and updates iload
    e.instr = 1; e.wr = 0; e.addr = 32'h44; e.data = ref_rd(32'h44);
    sbq.push_back(e);
    fixed_delay = 3;
    @(posedge CLK); #2;
    iREN = 1; iaddr = 32'h44;
    @(negedge CLK);
    @(negedge CLK);
    @(posedge CLK); #2 iREN = 0;
    for (int c = 0; c < 20 && (ramREN || sbq.size() > 0); c++) @(negedge CLK);
    check("withdrawn_iload", iload, e.data);
    check("withdrawn_idle", 32'(ramREN), 0);
    fixed_delay = -1;

    // asynchronous reset in the middle of an instruction access
    stall = 1;
    @(posedge CLK); #2;
    iREN = 1; iaddr = 32'h48;
    repeat (3) @(negedge CLK);
    #1 nRST = 1'b0;
    #1;
    check("rstmid_ramREN", 32'(ramREN), 0);
    check("rstmid_iload", iload, 0);
    clear_model();
    iREN = 0;
    @(posedge CLK); #3;
    nRST = 1'b1; stall = 0;
    inject_ready = 1;
    @(posedge CLK); #2 inject_ready = 0;
    @(negedge CLK);
    check("spurious_iload", iload, 0);
    check("spurious_dload", dload, 0);
    @(negedge CLK);
    check("spurious_idle", 32'(ramREN || ramWEN), 0);

    // RAM never answers: ERR after four waiting cycles
    stall = 1;
    @(posedge CLK); #2;
    dREN = 1; daddr = 32'h300;
    @(negedge CLK);
    check("to_req_cycle_en", 32'(ramREN), 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      check("to_wait_ramREN", 32'(ramREN), 1);
      check("to_wait_timeout", 32'(timeout), 0);
    end
    @(negedge CLK);
    check("to_err_timeout", 32'(timeout), 1);
    check("to_err_ramREN", 32'(ramREN), 0);
    check("to_err_ramWEN", 32'(ramWEN), 0);
    check("to_err_dwait", 32'(dwait), 1);
    inject_ready = 1;
    repeat (3) begin
      @(negedge CLK);
      check("to_sticky", 32'(timeout), 1);
      check("to_sticky_en", 32'(ramREN || ramWEN), 0);
    end
    inject_ready = 0;
    #1 nRST = 1'b0;
    #1;
    check("to_rst_timeout", 32'(timeout), 0);
    check("to_rst_ramaddr", ramaddr, 0);
    clear_model();
    dREN = 0;
    @(posedge CLK); #3;
    nRST = 1'b1; stall = 0;

    issue(0, 1, 32'h0, 32'h300, 32'h0);
    issue(1, 3, 32'h8, 32'h8, 32'h0BAD_F00D);
    check("post_rst_sb_empty", 32'(sbq.size()), 0);

    repeat (3) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-ported RAM between the instruction fetch path and the data path of the CPU. It latches one request at a time, drives the RAM handshake, and returns load data and wait signals to the requester. The control unit's `iread`, `dread` and `dwrite` outputs enable the requests, after any request-unit gating. The block sits between the datapath/request unit and the RAM, and enforces data-over-instruction priority, halt gating and a RAM-timeout error.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles an access may wait for `ramready` before the block declares an error. Legal range is 1 to 1023.

Ports:
- `CLK` in 1: the single clock; all state updates on the rising edge.
- `nRST` in 1: reset, asynchronous and active-low.
- `iREN` in 1: instruction read request, level-held until the access completes.
- `iaddr` in 32: instruction word address.
- `iwait` out 1: instruction access not yet complete.
- `iload` out 32: instruction read data.
- `dREN` in 1: data read request, level-held.
- `dWEN` in 1: data write request, level-held.
- `daddr` in 32: data address.
- `dstore` in 32: data write value.
- `dwait` out 1: data access not yet complete.
- `dload` out 32: data read data.
- `halt` in 1: the CPU has halted; no new instruction grants are issued.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data, valid in the cycle `ramready` is high.
- `ramready` in 1: RAM completion pulse, one cycle, for the current access.
- `timeout` out 1: sticky error flag.

## Operation

State machine states:
- IDLE: no access in flight.
- IACC: instruction access in flight.
- DACC: data access in flight.
- ERR: sticky error.

IDLE transitions:
- If `dREN` or `dWEN` is high, go to DACC.
  - Latch `daddr` and `dstore`.
  - Latch the operation: write if `dWEN` is high, otherwise read. When `dREN` and `dWEN` are both high, the access is a write.
- Else if `iREN` is high and `halt` is low, go to IACC and latch `iaddr`.
- Else stay in IDLE.
- Data always wins over instruction when both request in the same cycle.

IACC / DACC behaviour:
- `ramaddr`, `ramstore` and `ramREN`/`ramWEN` are driven from the latched registers only. Input changes mid-access are ignored.
- IACC drives `ramREN=1`. DACC drives either `ramREN=1` or `ramWEN=1`, never both.
- When `ramready` is high, the access completes and the state returns to IDLE on the next edge.
- While `ramready` is low, the timeout counter increments. When the counter reaches `TIMEOUT_CYCLES`, the state goes to ERR.

ERR behaviour:
- `timeout=1`.
- `ramREN=0` and `ramWEN=0`.
- `iwait` and `dwait` follow their requests, so requesters freeze.
- Only `nRST` exits ERR.

Completion and outputs:
- `iwait` = `iREN` AND NOT (state is IACC AND `ramready`).
- `dwait` = (`dREN` OR `dWEN`) AND NOT (state is DACC AND `ramready`).
- `iload`: a register updated from `ramload` on an IACC completion edge. The output is `ramload` during the completion cycle and the register value otherwise.
- `dload`: same as `iload`, updated on a DACC read completion only. A write leaves `dload` unchanged.
- A request withdrawn mid-access still completes on the RAM. No wait pulse is produced for it, and the load register is still updated.
- `halt` does not abort an IACC already in flight.
- The `ramaddr` and `ramstore` registers hold their values in IDLE and ERR.

Reset (asynchronous, `nRST` low):
- State goes to IDLE.
- Cleared to 0: the timeout counter, all latched registers, `iload`/`dload` registers, `ramREN`, `ramWEN`, `ramaddr`, `ramstore` and `timeout`.
- Reset mid-access abandons the access. No completion is reported.

## Timing

- The request is seen in IDLE at cycle N.
- The RAM enable is high from cycle N+1.
- If `ramready` arrives at cycle N+k (k≥1), the wait signal is low in cycle N+k, the data is valid in that cycle, and the state is IDLE at N+k+1.
- Minimum latency: 2 cycles from request to completion.
- Back-to-back accesses cost at least 2 cycles each, because one IDLE cycle always separates accesses.
- A `ramready` seen in IDLE or ERR is ignored.
- The counter counts cycles in IACC/DACC with `ramready` low, starting at 0 on entry.
  - Timeout occurs on the edge after the `TIMEOUT_CYCLES`-th such cycle.
  - A `ramready` arriving in the same cycle as the terminal count wins, and the access completes.
- The counter is wide enough for the largest legal `TIMEOUT_CYCLES` (10 bits).

## Test plan

- **Instruction fetch:** raise `iREN` with `iaddr=0x40` while IDLE; RAM asserts `ramready` 2 cycles after `ramREN` with `ramload=0x8C220004`. Required: `ramaddr=0x40`, and `iwait` low only in the `ramready` cycle with `iload=0x8C220004`.
- **Data priority:** raise `iREN` and `dWEN` together with `daddr=0x100` and `dstore=0xDEADBEEF`. Required: DACC first with `ramWEN=1`; `iwait` stays high; IACC starts after one IDLE cycle.
- **Halt gating:** hold `halt=1` and `iREN=1` with no data request. Required: no RAM enable is ever asserted. A `dREN` to 0x200 is still served, with `dload` taking `ramload`.
- **Timeout:** `TIMEOUT_CYCLES=4`, issue `dREN`, never assert `ramready`. Required: ERR after 4 waiting cycles, `timeout=1`, `ramREN=0`, `dwait` stays 1. After `nRST`, `timeout=0` and the block returns to IDLE.
- **Reset mid-access:** assert `nRST` low during IACC. Required: immediate asynchronous `ramREN=0` and state IDLE. A subsequent `ramready` is ignored and `iload` is 0.
- **Withdrawn request:** drop `iREN` during IACC, then assert `ramready`. Required: `iwait` shows no completion pulse, the `iload` register updates, and the next state is IDLE.
